// File: rtl/sram_bank_responder.sv
// Responder side of the multi-bank SRAM interface: eight independent single-port banks
// on a shared address bus, fixed read latency, sticky protocol-error flags.
module sram_bank_responder #(
  parameter int NUM_BANKS = 8,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_BANKS-1:0]                 cs_i,
  input  logic [NUM_BANKS-1:0]                 w_trigger_i,
  input  logic [NUM_BANKS-1:0]                 r_trigger_i,
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]     write_data_i,
  input  logic                                 err_clr_i,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]     read_data_o,
  output logic [NUM_BANKS-1:0]                 rd_valid_o,
  output logic [NUM_BANKS-1:0]                 busy_o,
  output logic                                 err_busy_o,
  output logic                                 err_conflict_o,
  output logic                                 err_range_o
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  LAT_M1  = 3'(RD_LAT - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  logic             addr_ok;
  logic [IDX_W-1:0] idx;
  logic [NUM_BANKS-1:0] set_busy, set_conflict, set_range;

  assign addr_ok = ({1'b0, addr_i} < DEPTH_C);
  assign idx     = addr_i[IDX_W-1:0];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    state_e           state_q, state_d;
    logic [2:0]       cnt_q;
    logic [IDX_W-1:0] raddr_q;
    logic             raddr_ok_q;
    logic [DATA_W-1:0] rdata_q;
    logic             rvalid_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic             hit, is_busy, done, acc_wr, acc_rd;

    assign hit = cs_i[g] & (w_trigger_i[g] | r_trigger_i[g]);

    always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (acc_rd) state_d = RD_WAIT;
        RD_WAIT: if (done)   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // A simultaneous write wins over the read, so the read is only accepted alone.
    always_comb begin
      is_busy = (state_q == RD_WAIT);
      done    = is_busy && (cnt_q == 3'd0);
      acc_wr  = !is_busy && cs_i[g] && w_trigger_i[g];
      acc_rd  = !is_busy && cs_i[g] && r_trigger_i[g] && !w_trigger_i[g];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q      <= '0;
        raddr_q    <= '0;
        raddr_ok_q <= 1'b0;
        rdata_q    <= '0;
        rvalid_q   <= 1'b0;
      end else begin
        rvalid_q <= done;
        if (acc_rd) begin
          cnt_q      <= LAT_M1;
          raddr_q    <= idx;
          raddr_ok_q <= addr_ok;
        end else if (is_busy && cnt_q != 3'd0) begin
          cnt_q <= cnt_q - 3'd1;
        end
        if (done) rdata_q <= raddr_ok_q ? mem[raddr_q] : '0;
      end
    end

    // Storage is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk_i) begin
      if (acc_wr && addr_ok) mem[idx] <= write_data_i[g];
    end

    assign read_data_o[g]  = rdata_q;
    assign rd_valid_o[g]   = rvalid_q;
    assign busy_o[g]       = is_busy;
    assign set_busy[g]     = is_busy & hit;
    assign set_conflict[g] = !is_busy & cs_i[g] & w_trigger_i[g] & r_trigger_i[g];
    assign set_range[g]    = !is_busy & hit & !addr_ok;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_busy_o     <= 1'b0;
      err_conflict_o <= 1'b0;
      err_range_o    <= 1'b0;
    end else begin
      err_busy_o     <= (|set_busy)     | (err_busy_o     & !err_clr_i);
      err_conflict_o <= (|set_conflict) | (err_conflict_o & !err_clr_i);
      err_range_o    <= (|set_range)    | (err_range_o    & !err_clr_i);
    end
  end

endmodule

// File: tb/tb_sram_bank_responder.sv
// Bench for sram_bank_responder: directed scenarios plus randomized write/read traffic
// checked against an associative-array memory model.
module tb_sram_bank_responder;
  localparam int NB = 8, DW = 64, AW = 10, DEPTH = 512, LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0] cs, w, r;
  logic [AW-1:0] addr;
  logic [NB-1:0][DW-1:0] wd;
  logic clr;
  logic [NB-1:0][DW-1:0] rd;
  logic [NB-1:0] rv, busy;
  logic eb, ec, er;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [int];

  sram_bank_responder #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .w_trigger_i(w), .r_trigger_i(r), .addr_i(addr),
    .write_data_i(wd), .err_clr_i(clr), .read_data_o(rd), .rd_valid_o(rv), .busy_o(busy),
    .err_busy_o(eb), .err_conflict_o(ec), .err_range_o(er));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = '0; w = '0; r = '0; clr = 1'b0;
  endtask

  task automatic clear_errors();
    idle(); clr = 1'b1; step(); clr = 1'b0;
  endtask

  // Model: an accepted in-range write stores the word; everything else leaves memory alone.
  task automatic model_write(input logic [NB-1:0] mask, input int a, input logic [NB-1:0][DW-1:0] d);
    if (a < DEPTH)
      for (int b = 0; b < NB; b++)
        if (mask[b]) ref_mem[b*1024 + a] = d[b];
  endtask

  function automatic logic [DW-1:0] model_read(input int b, input int a);
    if (a >= DEPTH) return '0;
    if (ref_mem.exists(b*1024 + a)) return ref_mem[b*1024 + a];
    return 'x;
  endfunction

  task automatic write_word(input int b, input int a, input logic [DW-1:0] d);
    idle(); cs[b] = 1'b1; w[b] = 1'b1; addr = AW'(a); wd[b] = d;
    step();
    model_write(NB'(1) << b, a, wd);
    idle();
  endtask

  // Counts edges after the accepting edge until any rd_valid appears (bounded).
  task automatic wait_valid(output int edges);
    edges = 0;
    while (rv == '0 && edges < 20) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; addr = '0; wd = '0;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (rd !== '0)   begin errors++; $display("FAIL reset_read_data got %h exp 0", rd); end
    checks++; if (rv !== '0)   begin errors++; $display("FAIL reset_rd_valid got %h exp 0", rv); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    checks++; if ({eb, ec, er} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", {eb, ec, er}); end
  endtask

  task automatic test_basic();
    int edges, busy_cnt;
    write_word(0, 5, 64'h1111_2222_3333_4444);
    cs = 8'h01; r = 8'h01; addr = 10'd5;
    step();
    idle(); addr = AW'($urandom);
    busy_cnt = busy[0] ? 1 : 0;
    edges = 0;
    while (rv == '0 && edges < 20) begin
      step();
      edges++;
      if (busy[0]) busy_cnt++;
    end
    checks++; if (edges !== LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", edges, LAT); end
    checks++; if (busy_cnt !== LAT) begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", busy_cnt, LAT); end
    checks++; if (rv !== 8'h01) begin errors++; $display("FAIL basic_rd_valid got %h exp 01", rv); end
    checks++; if (rd[0] !== model_read(0, 5)) begin errors++; $display("FAIL basic_data got %h exp %h", rd[0], model_read(0, 5)); end
    step();
    checks++; if (rv !== '0) begin errors++; $display("FAIL basic_valid_pulse got %h exp 00", rv); end
    checks++; if (rd[0] !== model_read(0, 5)) begin errors++; $display("FAIL basic_hold got %h exp %h", rd[0], model_read(0, 5)); end
  endtask

  task automatic test_all_banks();
    int edges;
    idle(); addr = '0;
    for (int b = 0; b < NB; b++) wd[b] = (b == 0) ? {8{8'h12}} : {16{4'(b + 1)}};
    cs = '1; w = '1;
    step();
    model_write('1, 0, wd);
    idle(); cs = '1; r = '1;
    step();
    idle();
    wait_valid(edges);
    checks++; if (edges !== LAT) begin errors++; $display("FAIL all_latency got %0d exp %0d", edges, LAT); end
    checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL all_rd_valid got %h exp ff", rv); end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (rd[b] !== model_read(b, 0)) begin errors++; $display("FAIL all_data bank %0d got %h exp %h", b, rd[b], model_read(b, 0)); end
    end
  endtask

  task automatic test_random();
    int a, edges;
    logic [NB-1:0] eff;
    for (int it = 0; it < 24; it++) begin
      clear_errors();
      a = $urandom_range(0, 1023);
      addr = AW'(a);
      cs = NB'($urandom); w = NB'($urandom); r = '0;
      for (int b = 0; b < NB; b++) wd[b] = {$urandom(), $urandom()};
      eff = cs & w;
      step();
      model_write(eff, a, wd);
      idle();
      if (eff == '0) continue;
      cs = eff; r = '1; addr = AW'(a);
      step();
      idle();
      wait_valid(edges);
      checks++; if (edges !== LAT) begin errors++; $display("FAIL rand_latency it %0d got %0d exp %0d", it, edges, LAT); end
      checks++; if (rv !== eff) begin errors++; $display("FAIL rand_rd_valid it %0d got %h exp %h", it, rv, eff); end
      for (int b = 0; b < NB; b++)
        if (eff[b]) begin
          checks++;
          if (rd[b] !== model_read(b, a)) begin
            errors++; $display("FAIL rand_data it %0d bank %0d addr %0d got %h exp %h", it, b, a, rd[b], model_read(b, a));
          end
        end
      checks++; if (er !== (a >= DEPTH)) begin errors++; $display("FAIL rand_err_range it %0d got %b exp %b", it, er, a >= DEPTH); end
      checks++; if ({eb, ec} !== 2'b00) begin errors++; $display("FAIL rand_other_errs it %0d got %b exp 00", it, {eb, ec}); end
    end
  endtask

  task automatic test_busy();
    int edges;
    write_word(3, 7, 64'h0123_4567_89AB_CDEF);
    clear_errors();
    cs = 8'h08; r = 8'h08; addr = 10'd7;
    step();
    idle(); cs = 8'h08; w = 8'h08; addr = 10'd7; wd[3] = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    idle();
    checks++; if (eb !== 1'b1) begin errors++; $display("FAIL busy_err got %b exp 1", eb); end
    cs = 8'h08; r = 8'h08; addr = 10'd7;
    step();
    idle();
    checks++; if (rv !== 8'h08) begin errors++; $display("FAIL busy_rd_valid got %h exp 08", rv); end
    checks++; if (rd[3] !== model_read(3, 7)) begin errors++; $display("FAIL busy_old_data got %h exp %h", rd[3], model_read(3, 7)); end
    checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL busy_b2b_rejected got %b exp 0", busy[3]); end
    cs = 8'h08; r = 8'h08; addr = 10'd7;
    step();
    idle();
    wait_valid(edges);
    checks++; if (rd[3] !== model_read(3, 7)) begin errors++; $display("FAIL busy_mem_unchanged got %h exp %h", rd[3], model_read(3, 7)); end
  endtask

  task automatic test_conflict();
    int edges;
    logic seen;
    clear_errors();
    cs = 8'h04; r = 8'h04; w = 8'h04; addr = 10'd9; wd[2] = {4{16'hAAAA}};
    step();
    model_write(8'h04, 9, wd);
    idle();
    checks++; if (ec !== 1'b1) begin errors++; $display("FAIL conflict_err got %b exp 1", ec); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL conflict_busy got %b exp 0", busy[2]); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); seen |= rv[2]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL conflict_no_valid got %b exp 0", seen); end
    cs = 8'h04; r = 8'h04; addr = 10'd9;
    step();
    idle();
    wait_valid(edges);
    checks++; if (rd[2] !== model_read(2, 9)) begin errors++; $display("FAIL conflict_data got %h exp %h", rd[2], model_read(2, 9)); end
  endtask

  task automatic test_range();
    int edges;
    clear_errors();
    cs = 8'h02; r = 8'h02; addr = 10'd600;
    step();
    idle();
    wait_valid(edges);
    checks++; if (rv !== 8'h02) begin errors++; $display("FAIL range_rd_valid got %h exp 02", rv); end
    checks++; if (rd[1] !== '0) begin errors++; $display("FAIL range_data got %h exp 0", rd[1]); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", er); end
    cs = 8'h40; w = 8'h40; addr = 10'd700; clr = 1'b1;
    step();
    idle();
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err_wins_clr got %b exp 1", er); end
    clr = 1'b1;
    step();
    idle();
    checks++; if ({eb, ec, er} !== 3'b000) begin errors++; $display("FAIL range_clear got %b exp 000", {eb, ec, er}); end
  endtask

  task automatic test_reset_mid_read();
    int edges;
    logic seen;
    write_word(5, 11, 64'hFEED_FACE_CAFE_F00D);
    cs = 8'h20; r = 8'h20; addr = 10'd11;
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== '0) begin errors++; $display("FAIL rstmid_busy got %h exp 0", busy); end
    checks++; if (rd[5] !== '0) begin errors++; $display("FAIL rstmid_data got %h exp 0", rd[5]); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin seen |= |rv; step(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got %b exp 0", seen); end
    cs = 8'h20; r = 8'h20; addr = 10'd11;
    step();
    idle();
    wait_valid(edges);
    checks++; if (rd[5] !== model_read(5, 11)) begin errors++; $display("FAIL rstmid_retained got %h exp %h", rd[5], model_read(5, 11)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_banks();
    test_random();
    test_busy();
    test_conflict();
    test_range();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bank_responder.md
# sram_bank_responder

Responder end of the multi-bank SRAM interface driven by `sram_controller`. It models eight independent single-port banks sharing one address bus, and accepts per-bank write and read triggers qualified by chip select. Read data returns after a fixed latency with a valid pulse. Protocol violations are flagged in sticky error bits so controller benches and the integrated array can detect misuse.

## Interface
- `NUM_BANKS`, 8, number of banks; one bit of each trigger/cs vector per bank
- `DATA_W`, 64, word width per bank
- `ADDR_W`, 10, shared address width
- `DEPTH`, 1024, words per bank; must be ≤ 2**ADDR_W
- `RD_LAT`, 2, cycles from read accept to data valid; legal range 1..7

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cs`  in  NUM_BANKS  per-bank chip select
- `w_trigger`  in  NUM_BANKS  per-bank write request; effective only with matching `cs`
- `r_trigger`  in  NUM_BANKS  per-bank read request; effective only with matching `cs`
- `addr`  in  ADDR_W  shared word address, sampled at accept
- `write_data`  in  NUM_BANKS×DATA_W  packed per-bank write words; bank b uses slice b
- `err_clr`  in  1  clears all sticky error bits
- `read_data`  out  NUM_BANKS×DATA_W  per-bank read words; held until the next read completes
- `rd_valid`  out  NUM_BANKS  one-cycle pulse per completed read
- `busy`  out  NUM_BANKS  bank has a read in flight
- `err_busy`  out  1  sticky: trigger arrived at a busy bank
- `err_conflict`  out  1  sticky: read and write issued to the same bank in the same cycle
- `err_range`  out  1  sticky: accepted access with `addr` ≥ DEPTH

## Operation
- Each bank has an independent FSM with states IDLE and RD_WAIT, plus a 3-bit latency counter.
- An access is effective in bank b when `cs[b]` is high and either `w_trigger[b]` or `r_trigger[b]` is high. A trigger without `cs` is ignored silently.
- IDLE, effective write only: `mem_b[addr] <= write_data[b]` at the edge. The bank stays in IDLE.
- IDLE, effective read only: latch `addr`, load counter = RD_LAT-1, go to RD_WAIT, and assert `busy[b]`.
- IDLE, read and write in the same cycle:
  - The write is performed.
  - The read is dropped.
  - `err_conflict` is set.
  - The bank stays in IDLE.
- RD_WAIT: decrement the counter each cycle. When the counter is 0, at the edge load `read_data[b]` from the latched address, pulse `rd_valid[b]`, clear `busy[b]`, and return to IDLE.
- RD_WAIT, any effective trigger: the trigger is ignored (no write, no new read) and `err_busy` is set.
- Out of range (`addr` ≥ DEPTH): a write is discarded, and a read returns all zeros with a normal `rd_valid`. Both set `err_range`.
- Read data comes from memory at completion time. A write cannot occur to a bank while it is in RD_WAIT, so no forwarding is needed.
- Errors are sticky until `err_clr` or `rst`. If `err_clr` and a new error occur in the same cycle, the error wins and the bit stays set.
- Banks are fully independent. Any mix of banks may read and write in the same cycle.

## Timing
- Reset values:
  - `read_data` = 0
  - `rd_valid` = 0
  - `busy` = 0
  - all `err_*` = 0
  - all FSMs in IDLE
- Memory contents are not reset and are retained across `rst`.
- Write: takes effect at the accepting edge k. A read accepted at edge k+1 returns the new word.
- Read: accepted at edge k. `busy` is high from after edge k until after edge k+RD_LAT. `read_data` and `rd_valid` update at edge k+RD_LAT, with `rd_valid` high for exactly one cycle.
- Back-to-back reads: the earliest new accept is edge k+RD_LAT, the cycle in which `busy` is still high. A trigger in that cycle is rejected with `err_busy`. The next legal accept is edge k+RD_LAT+1.
- RD_LAT=1: the counter starts at 0 and the data is valid one edge after accept.
- `rst` mid-read: the FSM is forced to IDLE, no `rd_valid` is produced, and `read_data` is cleared to 0.

## Test plan
- Write 64'h1111_2222_3333_4444 to bank 0 at addr 5, then read bank 0 addr 5 with RD_LAT=2 → `rd_valid[0]` pulses exactly 2 edges after accept, `read_data[0]` = 64'h1111_2222_3333_4444, and `busy[0]` is high for 2 cycles.
- Write eight distinct words (64'h1212…, 64'h2222…, …, 64'h8888…) to banks 0–7 at addr 0 in one cycle, then read all eight in one cycle → all `rd_valid` bits pulse together, and each slice matches its word.
- Read bank 3, then issue a write to bank 3 at the next edge → the write is ignored, `err_busy` = 1, the original read returns the old data, and a later read shows the memory unchanged.
- Assert `cs[2]`, `r_trigger[2]` and `w_trigger[2]` together with data 64'hAAAA… → `err_conflict` = 1, no `rd_valid[2]`, and a subsequent read returns 64'hAAAA….
- With DEPTH=512, read addr 600 → `read_data` = 0, `rd_valid` pulses, and `err_range` = 1. Then assert `err_clr` → all errors return to 0.
- Assert `rst` one cycle after a read accept → no `rd_valid`, `busy` = 0, and a fresh read afterward returns the data written before reset.
